// File: rtl/dii_buffer_pkg.sv
// Shared types and helpers for the DII packet buffer: flit layout and modulo pointer increment.
package dii_buffer_pkg;

  localparam int FLIT_WIDTH = 16;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic                  first;
    logic                  last;
  } flit_t;

  // Explicit wrap so depths that are not a power of two still cycle correctly.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dii_packet_buffer_mem.sv
// Flit storage for the DII packet buffer: DEPTH x DW register array, one write port, async read.
module dii_packet_buffer_mem #(
  parameter int DW    = 18,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dii_packet_buffer.sv
// Circular DII flit buffer with fill/packet counters and optional store-and-forward mode.
// Optional almost_full output enabled by DII_PACKET_BUFFER_ALMOST_FULL_EN.
module dii_packet_buffer
  import dii_buffer_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 8,
  parameter int FULLPACKET   = 0,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic [$clog2(DEPTH+1)-1:0] packet_count
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
  ,
  output logic                       almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_fill;
  logic [CW-1:0]      r_pkt;
  logic               r_in_progress;
  logic [CW-1:0]      w_fill_next;
  logic [CW-1:0]      w_pkt_next;
  logic               w_push;
  logic               w_pop;
  logic               w_pkt_inc;
  logic               w_pkt_dec;
  logic [WIDTH+1:0]   w_rdata;

  dii_packet_buffer_mem #(
    .DW   (WIDTH + 2),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_mem (
    .i_clk  (clk),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata({in_data, in_first, in_last}),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );

  assign in_ready     = (r_fill != FULL_C);
  assign w_push       = in_valid & in_ready;
  assign w_pop        = out_valid & out_ready;
  assign w_pkt_inc    = w_push & in_last;
  assign w_pkt_dec    = w_pop & out_last;
  assign out_data     = w_rdata[WIDTH+1:2];
  assign out_first    = w_rdata[1];
  assign out_last     = w_rdata[0];
  assign fill_level   = r_fill;
  assign packet_count = r_pkt;

  generate
    if (FULLPACKET != 0) begin : g_fullpacket
      // Full buffer forces cut-through so an oversized packet cannot deadlock.
      assign out_valid = (r_fill != '0) &
                         ((r_pkt != '0) | r_in_progress | (r_fill == FULL_C));
    end else begin : g_stream
      assign out_valid = (r_fill != '0);
    end
  endgenerate

  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + 1'b1;
      2'b01:   w_fill_next = r_fill - 1'b1;
      default: w_fill_next = r_fill;
    endcase
  end

  always_comb begin
    w_pkt_next = r_pkt;
    case ({w_pkt_inc, w_pkt_dec})
      2'b10:   w_pkt_next = r_pkt + 1'b1;
      2'b01:   w_pkt_next = r_pkt - 1'b1;
      default: w_pkt_next = r_pkt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      r_pkt         <= '0;
      r_in_progress <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      if (w_pop) begin
        r_rd_ptr      <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
        r_in_progress <= ~out_last;
      end
      r_fill <= w_fill_next;
      r_pkt  <= w_pkt_next;
    end
  end

`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  logic r_almost_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_almost_full <= 1'b0;
    else     r_almost_full <= (w_fill_next >= AFULL_C);
  end

  assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_dii_packet_buffer.sv
// Directed bench for dii_packet_buffer: four instances covering streaming, wrap, store-and-forward, escape.
module tb_dii_packet_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // a: DEPTH 8 stream, b: DEPTH 5 stream, c: DEPTH 8 full-packet, d: DEPTH 4 full-packet
  logic [15:0] a_id, b_id, c_id, d_id;
  logic        a_if, b_if, c_if, d_if;
  logic        a_il, b_il, c_il, d_il;
  logic        a_iv, b_iv, c_iv, d_iv;
  logic        a_ir, b_ir, c_ir, d_ir;
  logic [15:0] a_od, b_od, c_od, d_od;
  logic        a_of, b_of, c_of, d_of;
  logic        a_ol, b_ol, c_ol, d_ol;
  logic        a_ov, b_ov, c_ov, d_ov;
  logic        a_or, b_or, c_or, d_or;
  logic [3:0]  a_fl, c_fl, a_pc, c_pc;
  logic [2:0]  b_fl, d_fl, b_pc, d_pc;
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
  logic        a_af, b_af, c_af, d_af;
`endif

  dii_packet_buffer #(.WIDTH(16), .DEPTH(8), .FULLPACKET(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_id), .in_first(a_if), .in_last(a_il),
    .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od), .out_first(a_of),
    .out_last(a_ol), .out_valid(a_ov), .out_ready(a_or), .fill_level(a_fl),
    .packet_count(a_pc)
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
    , .almost_full(a_af)
`endif
  );

  dii_packet_buffer #(.WIDTH(16), .DEPTH(5), .FULLPACKET(0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_id), .in_first(b_if), .in_last(b_il),
    .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_first(b_of),
    .out_last(b_ol), .out_valid(b_ov), .out_ready(b_or), .fill_level(b_fl),
    .packet_count(b_pc)
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
    , .almost_full(b_af)
`endif
  );

  dii_packet_buffer #(.WIDTH(16), .DEPTH(8), .FULLPACKET(1)) u_c (
    .clk(clk), .rst(rst), .in_data(c_id), .in_first(c_if), .in_last(c_il),
    .in_valid(c_iv), .in_ready(c_ir), .out_data(c_od), .out_first(c_of),
    .out_last(c_ol), .out_valid(c_ov), .out_ready(c_or), .fill_level(c_fl),
    .packet_count(c_pc)
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
    , .almost_full(c_af)
`endif
  );

  dii_packet_buffer #(.WIDTH(16), .DEPTH(4), .FULLPACKET(1)) u_d (
    .clk(clk), .rst(rst), .in_data(d_id), .in_first(d_if), .in_last(d_il),
    .in_valid(d_iv), .in_ready(d_ir), .out_data(d_od), .out_first(d_of),
    .out_last(d_ol), .out_valid(d_ov), .out_ready(d_or), .fill_level(d_fl),
    .packet_count(d_pc)
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
    , .almost_full(d_af)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    {a_id, b_id, c_id, d_id} = '0;
    {a_if, b_if, c_if, d_if} = '0;
    {a_il, b_il, c_il, d_il} = '0;
    {a_iv, b_iv, c_iv, d_iv} = '0;
    {a_or, b_or, c_or, d_or} = '0;
    #12;
    n_vec++;
    if ({a_ov, b_ov, c_ov, d_ov} !== 4'b0000) begin
      n_err++; $display("FAIL reset_out_valid got %b exp 0000", {a_ov, b_ov, c_ov, d_ov});
    end
    n_vec++;
    if ({a_ir, b_ir, c_ir, d_ir} !== 4'b1111) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 1111", {a_ir, b_ir, c_ir, d_ir});
    end
    n_vec++;
    if (a_fl !== 4'd0 || b_fl !== 3'd0 || c_fl !== 4'd0 || d_fl !== 3'd0) begin
      n_err++; $display("FAIL reset_fill got %0d %0d %0d %0d exp 0", a_fl, b_fl, c_fl, d_fl);
    end
    n_vec++;
    if (a_pc !== 4'd0 || b_pc !== 3'd0 || c_pc !== 4'd0 || d_pc !== 3'd0) begin
      n_err++; $display("FAIL reset_pkt got %0d %0d %0d %0d exp 0", a_pc, b_pc, c_pc, d_pc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    a_or = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_vec++;
        if (a_ov !== 1'b0) begin
          n_err++; $display("FAIL stream_empty_valid got %b exp 0", a_ov);
        end
      end else begin
        n_vec++;
        if (a_ov !== 1'b1 || a_od !== 16'(i - 1) || a_fl !== 4'd1) begin
          n_err++;
          $display("FAIL stream_flit%0d got v=%b d=%h fl=%0d exp v=1 d=%h fl=1", i - 1, a_ov, a_od, a_fl, 16'(i - 1));
        end
      end
      a_iv = 1'b1; a_id = 16'(i); a_if = (i == 1); a_il = (i == 8);
    end
    @(negedge clk);
    a_iv = 1'b0;
    n_vec++;
    if (a_ov !== 1'b1 || a_od !== 16'h0008 || a_ol !== 1'b1 || a_pc !== 4'd1) begin
      n_err++; $display("FAIL stream_last got v=%b d=%h l=%b pc=%0d exp v=1 d=0008 l=1 pc=1", a_ov, a_od, a_ol, a_pc);
    end
    @(negedge clk);
    n_vec++;
    if (a_ov !== 1'b0 || a_fl !== 4'd0 || a_pc !== 4'd0) begin
      n_err++; $display("FAIL stream_drained got v=%b fl=%0d pc=%0d exp 0 0 0", a_ov, a_fl, a_pc);
    end
    a_or = 1'b0;
  endtask

  task automatic test_fill_wrap();
    logic [15:0] exp_q [5];
    b_or = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (b_ir !== 1'b1) begin
        n_err++; $display("FAIL wrap_ready_%0d got %b exp 1", i, b_ir);
      end
      b_iv = 1'b1; b_id = 16'(i); b_if = (i == 1); b_il = 1'b0;
    end
    @(negedge clk);
    b_iv = 1'b0;
    n_vec++;
    if (b_ir !== 1'b0 || b_fl !== 3'd5 || b_od !== 16'h0001) begin
      n_err++; $display("FAIL wrap_full got rdy=%b fl=%0d d=%h exp rdy=0 fl=5 d=0001", b_ir, b_fl, b_od);
    end
    b_or = 1'b1;
    for (int j = 2; j <= 3; j++) begin
      @(negedge clk);
      n_vec++;
      if (b_od !== 16'(j)) begin
        n_err++; $display("FAIL wrap_pop_%0d got %h exp %h", j, b_od, 16'(j));
      end
    end
    @(negedge clk);
    b_or = 1'b0;
    n_vec++;
    if (b_fl !== 3'd2 || b_od !== 16'h0004) begin
      n_err++; $display("FAIL wrap_after_pop got fl=%0d d=%h exp fl=2 d=0004", b_fl, b_od);
    end
    for (int i = 0; i < 3; i++) begin
      b_iv = 1'b1; b_id = 16'(16'h000A + i); b_if = 1'b0; b_il = (i == 2);
      @(negedge clk);
    end
    b_iv = 1'b0;
    n_vec++;
    if (b_fl !== 3'd5 || b_ir !== 1'b0 || b_pc !== 3'd1) begin
      n_err++; $display("FAIL wrap_refill got fl=%0d rdy=%b pc=%0d exp fl=5 rdy=0 pc=1", b_fl, b_ir, b_pc);
    end
    exp_q[0] = 16'h0004; exp_q[1] = 16'h0005; exp_q[2] = 16'h000A;
    exp_q[3] = 16'h000B; exp_q[4] = 16'h000C;
    b_or = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (b_ov !== 1'b1 || b_od !== exp_q[k]) begin
        n_err++; $display("FAIL wrap_drain_%0d got v=%b d=%h exp v=1 d=%h", k, b_ov, b_od, exp_q[k]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (b_ov !== 1'b0 || b_fl !== 3'd0 || b_pc !== 3'd0) begin
      n_err++; $display("FAIL wrap_empty got v=%b fl=%0d pc=%0d exp 0 0 0", b_ov, b_fl, b_pc);
    end
    b_or = 1'b0;
  endtask

  task automatic test_store_forward();
    c_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (c_ov !== 1'b0) begin
        n_err++; $display("FAIL sf_hold_%0d got v=%b exp 0", i, c_ov);
      end
      c_iv = 1'b1; c_id = 16'(16'h0100 + i); c_if = (i == 0); c_il = (i == 2);
    end
    @(negedge clk);
    c_iv = 1'b0;
    n_vec++;
    if (c_ov !== 1'b1 || c_pc !== 4'd1 || c_fl !== 4'd3 || c_od !== 16'h0100 || c_of !== 1'b1) begin
      n_err++;
      $display("FAIL sf_release got v=%b pc=%0d fl=%0d d=%h f=%b exp v=1 pc=1 fl=3 d=0100 f=1", c_ov, c_pc, c_fl, c_od, c_of);
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (c_ov !== 1'b1 || c_od !== 16'(16'h0100 + i) || c_ol !== (i == 2)) begin
        n_err++; $display("FAIL sf_pop_%0d got v=%b d=%h l=%b", i, c_ov, c_od, c_ol);
      end
    end
    @(negedge clk);
    n_vec++;
    if (c_ov !== 1'b0 || c_fl !== 4'd0 || c_pc !== 4'd0) begin
      n_err++; $display("FAIL sf_drained got v=%b fl=%0d pc=%0d exp 0 0 0", c_ov, c_fl, c_pc);
    end
    c_or = 1'b0;
  endtask

  task automatic test_escape();
    int  idx_in  = 0;
    int  idx_out = 0;
    bit  seen_valid = 1'b0;
    d_or = 1'b1;
    for (int cyc = 0; cyc < 40 && idx_out < 6; cyc++) begin
      @(negedge clk);
      if (d_ov) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          n_vec++;
          if (d_fl !== 3'd4) begin
            n_err++; $display("FAIL esc_rise_fill got %0d exp 4", d_fl);
          end
        end
        n_vec++;
        if (d_od !== 16'(16'h0200 + idx_out) || d_ol !== (idx_out == 5)) begin
          n_err++;
          $display("FAIL esc_flit_%0d got d=%h l=%b exp d=%h l=%b", idx_out, d_od, d_ol, 16'(16'h0200 + idx_out), (idx_out == 5));
        end
        idx_out++;
      end
      if (idx_in < 6) begin
        d_iv = 1'b1; d_id = 16'(16'h0200 + idx_in); d_if = (idx_in == 0); d_il = (idx_in == 5);
        if (d_ir) idx_in++;
      end else begin
        d_iv = 1'b0;
      end
    end
    d_iv = 1'b0;
    n_vec++;
    if (idx_out != 6) begin
      n_err++; $display("FAIL esc_timeout got %0d flits exp 6", idx_out);
    end
    @(negedge clk);
    n_vec++;
    if (d_ov !== 1'b0 || d_fl !== 3'd0 || d_pc !== 3'd0) begin
      n_err++; $display("FAIL esc_drained got v=%b fl=%0d pc=%0d exp 0 0 0", d_ov, d_fl, d_pc);
    end
    // A lone non-last flit must now be held, showing the in-progress flag was cleared.
    d_iv = 1'b1; d_id = 16'h0300; d_if = 1'b1; d_il = 1'b0;
    @(negedge clk);
    d_iv = 1'b0;
    @(negedge clk);
    n_vec++;
    if (d_ov !== 1'b0 || d_fl !== 3'd1) begin
      n_err++; $display("FAIL esc_progress_clear got v=%b fl=%0d exp v=0 fl=1", d_ov, d_fl);
    end
    d_or = 1'b0;
  endtask

  task automatic test_simul_and_reset();
    a_or = 1'b0;
    @(negedge clk);
    a_iv = 1'b1; a_id = 16'h0055; a_if = 1'b1; a_il = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_fl !== 4'd1 || a_od !== 16'h0055) begin
      n_err++; $display("FAIL simul_pre got fl=%0d d=%h exp fl=1 d=0055", a_fl, a_od);
    end
    a_or = 1'b1; a_id = 16'h0066; a_if = 1'b0;
    @(negedge clk);
    n_vec++;
    if (a_fl !== 4'd1 || a_ov !== 1'b1 || a_od !== 16'h0066) begin
      n_err++; $display("FAIL simul_replace got fl=%0d v=%b d=%h exp fl=1 v=1 d=0066", a_fl, a_ov, a_od);
    end
    a_or = 1'b0; a_id = 16'h0077;
    @(negedge clk);
    a_iv = 1'b0;
    n_vec++;
    if (a_fl !== 4'd2) begin
      n_err++; $display("FAIL simul_grow got fl=%0d exp 2", a_fl);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_fl !== 4'd0 || a_pc !== 4'd0) begin
      n_err++; $display("FAIL async_rst got v=%b rdy=%b fl=%0d pc=%0d exp 0 1 0 0", a_ov, a_ir, a_fl, a_pc);
    end
    #1 rst = 1'b0;
  endtask

`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
  task automatic test_almost_full();
    a_or = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (a_fl !== 4'(i) || a_af !== (i >= 6)) begin
        n_err++; $display("FAIL afull_%0d got fl=%0d af=%b exp fl=%0d af=%b", i, a_fl, a_af, i, (i >= 6));
      end
      a_iv = (i < 6); a_id = 16'(i); a_if = 1'b0; a_il = 1'b0;
    end
    a_iv = 1'b0; a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
    n_vec++;
    if (a_fl !== 4'd5 || a_af !== 1'b0) begin
      n_err++; $display("FAIL afull_pop got fl=%0d af=%b exp fl=5 af=0", a_fl, a_af);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_fill_wrap();
    test_store_forward();
    test_escape();
    test_simul_and_reset();
`ifdef DII_PACKET_BUFFER_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
